// File: rtl/wallace_mult_pipe_pkg.sv
// mult_pkg: shared constants and helpers for the pipelined Wallace multiplier.
//   MODE_UNSIGNED / MODE_SIGNED : values carried on signed_mode.
//   prod_width()                : product width for a given operand width.
//   bw_correction()             : Baugh-Wooley correction constant.
package mult_pkg;

   localparam logic MODE_UNSIGNED = 1'b0;
   localparam logic MODE_SIGNED   = 1'b1;

   function automatic int prod_width(input int width);
      return 2 * width;
   endfunction

   // Modified Baugh-Wooley: with the sign-row/sign-column cross terms
   // inverted, adding 2^W + 2^(2W-1) restores the exact product mod 2^(2W).
   function automatic logic [63:0] bw_correction(input int width);
      return (64'd1 << width) | (64'd1 << (2 * width - 1));
   endfunction

endpackage

// File: rtl/wallace_mult_pipe_if.sv
// wallace_mult_pipe_if: operand-issue and result handshakes of the multiplier.
//   Issue side : in_valid, in_ready, A, B, signed_mode, in_tag
//   Result side: out_valid, out_ready, Z, out_tag
//   modport slave  - the multiplier itself
//   modport master - the surrounding datapath (issuer + consumer)
interface wallace_mult_pipe_if
   import mult_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
);
   logic                             in_valid;
   logic                             in_ready;
   logic [WIDTH-1:0]                 A;
   logic [WIDTH-1:0]                 B;
   logic                             signed_mode;
   logic [TAG_W-1:0]                 in_tag;
   logic                             out_valid;
   logic                             out_ready;
   logic [prod_width(WIDTH)-1:0]     Z;
   logic [TAG_W-1:0]                 out_tag;

   modport slave (
      input  in_valid, A, B, signed_mode, in_tag, out_ready,
      output in_ready, out_valid, Z, out_tag
   );

   modport master (
      output in_valid, A, B, signed_mode, in_tag, out_ready,
      input  in_ready, out_valid, Z, out_tag
   );
endinterface

// File: rtl/wallace_mult_pipe_reduce.sv
// csa_3to2     : W-bit 3:2 carry-save compressor; carry row comes out already
//                shifted to its weight (mod 2^W).
// wallace_reduce: combinational Wallace tree folding ROWS partial-product rows
//                 into a (sum, carry) pair whose total equals the row sum
//                 mod 2^(2*WIDTH).
//   pp    : partial-product rows, each pre-aligned to its weight
//   sum   : reduced sum row
//   carry : reduced carry row
module csa_3to2 #(
   parameter int W = 8
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic [W-1:0] z,
   output logic [W-1:0] sum,
   output logic [W-1:0] carry
);
   assign sum   = x ^ y ^ z;
   // Majority of the lower W-1 bits only: the top carry would fall off the row.
   assign carry = {(x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) |
                   (y[W-2:0] & z[W-2:0]), 1'b0};
endmodule

module wallace_reduce
   import mult_pkg::*;
#(
   parameter  int WIDTH = 16,
   localparam int PW    = prod_width(WIDTH),
   localparam int ROWS  = WIDTH + 1
) (
   input  logic [PW-1:0] pp [ROWS],
   output logic [PW-1:0] sum,
   output logic [PW-1:0] carry
);
   // Each level turns every group of three rows into two; leftovers pass through.
   function automatic int next_rows(input int r);
      return (r / 3) * 2 + (r % 3);
   endfunction

   function automatic int rows_at(input int lvl);
      int r;
      r = ROWS;
      for (int k = 0; k < lvl; k++) r = next_rows(r);
      return r;
   endfunction

   function automatic int num_levels(input int r0);
      int r;
      int n;
      r = r0;
      n = 0;
      while (r > 2) begin
         r = next_rows(r);
         n++;
      end
      return n;
   endfunction

   localparam int NLEV = num_levels(ROWS);

   logic [PW-1:0] lvl_s [0:NLEV][0:ROWS-1];

   for (genvar k = 0; k < ROWS; k++) begin : g_in
      assign lvl_s[0][k] = pp[k];
   end

   for (genvar l = 0; l < NLEV; l++) begin : g_lvl
      localparam int R  = rows_at(l);
      localparam int G  = R / 3;
      localparam int RN = next_rows(R);
      for (genvar g = 0; g < G; g++) begin : g_csa
         csa_3to2 #(.W(PW)) u_csa (
            .x     (lvl_s[l][3*g]),
            .y     (lvl_s[l][3*g+1]),
            .z     (lvl_s[l][3*g+2]),
            .sum   (lvl_s[l+1][2*g]),
            .carry (lvl_s[l+1][2*g+1])
         );
      end
      for (genvar k = 0; k < R - 3*G; k++) begin : g_pass
         assign lvl_s[l+1][2*G+k] = lvl_s[l][3*G+k];
      end
      // Slots beyond this level's live rows are tied off.
      for (genvar k = RN; k < ROWS; k++) begin : g_zero
         assign lvl_s[l+1][k] = '0;
      end
   end

   assign sum   = lvl_s[NLEV][0];
   assign carry = lvl_s[NLEV][1];
endmodule

// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: three-stage pipelined WIDTH x WIDTH multiplier, unsigned
// or two's-complement per transaction, with a pass-through tag.
//   clk, rst : clock and asynchronous active-high reset
//   io       : slave side of wallace_mult_pipe_if (issue + result handshakes)
// S1 holds operands, S2 holds the Wallace (sum, carry) rows, S3 holds Z.
module wallace_mult_pipe
   import mult_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   wallace_mult_pipe_if.slave  io
);
   localparam int          PW      = prod_width(WIDTH);
   localparam int          ROWS    = WIDTH + 1;
   localparam logic [63:0] BW_CORR = bw_correction(WIDTH);

   logic             v1_r, v2_r, v3_r;
   logic             adv1_s, adv2_s, adv3_s;
   logic [WIDTH-1:0] a_r, b_r;
   logic             mode_r;
   logic [TAG_W-1:0] tag1_r, tag2_r, tag3_r;
   logic [PW-1:0]    sum_r, carry_r, z_r;
   logic [PW-1:0]    pp_s [ROWS];
   logic [PW-1:0]    sum_s, carry_s;
   logic             pp_bit_s;

   // A stage may load when it is empty or its contents move on this edge.
   assign adv3_s = !v3_r || io.out_ready;
   assign adv2_s = !v2_r || adv3_s;
   assign adv1_s = !v1_r || adv2_s;

   assign io.in_ready  = adv1_s;
   assign io.out_valid = v3_r;
   assign io.Z         = z_r;
   assign io.out_tag   = tag3_r;

   // Partial-product rows; signed mode inverts the sign cross terms and adds
   // the Baugh-Wooley correction as an extra row.
   always_comb begin
      pp_bit_s = 1'b0;
      for (int i = 0; i < ROWS; i++) pp_s[i] = '0;
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            pp_bit_s = a_r[j] & b_r[i];
            if ((mode_r == MODE_SIGNED) && ((i == WIDTH-1) != (j == WIDTH-1))) begin
               pp_bit_s = ~pp_bit_s;
            end else begin
               pp_bit_s = pp_bit_s;
            end
            pp_s[i][i+j] = pp_bit_s;
         end
      end
      if (mode_r == MODE_SIGNED) begin
         pp_s[WIDTH] = BW_CORR[PW-1:0];
      end else begin
         pp_s[WIDTH] = '0;
      end
   end

   wallace_reduce #(.WIDTH(WIDTH)) u_reduce (
      .pp    (pp_s),
      .sum   (sum_s),
      .carry (carry_s)
   );

   // Stage S1: capture operands, mode and tag on an accepted transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_r   <= 1'b0;
         a_r    <= '0;
         b_r    <= '0;
         mode_r <= MODE_UNSIGNED;
         tag1_r <= '0;
      end else if (adv1_s) begin
         v1_r <= io.in_valid;
         if (io.in_valid) begin
            a_r    <= io.A;
            b_r    <= io.B;
            mode_r <= io.signed_mode;
            tag1_r <= io.in_tag;
         end
      end
   end

   // Stage S2: capture the reduced carry-save pair.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2_r    <= 1'b0;
         sum_r   <= '0;
         carry_r <= '0;
         tag2_r  <= '0;
      end else if (adv2_s) begin
         v2_r <= v1_r;
         if (v1_r) begin
            sum_r   <= sum_s;
            carry_r <= carry_s;
            tag2_r  <= tag1_r;
         end
      end
   end

   // Stage S3: final carry-propagate add; holds Z/out_tag while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v3_r   <= 1'b0;
         z_r    <= '0;
         tag3_r <= '0;
      end else if (adv3_s) begin
         v3_r <= v2_r;
         if (v2_r) begin
            z_r    <= sum_r + carry_r;
            tag3_r <= tag2_r;
         end
      end
   end
endmodule
